cdc_hs_tx: RTL and testbench
============================

# cdc_hs_tx

Source-side (transmitting) end of the team's toggle-handshake clock-domain-crossing link. The block accepts a WIDTH-bit word through a valid/ready interface and holds it stable on HsTx_DATA_OUT. It signals the word by toggling HsTx_REQ, then waits for the destination's returning acknowledge toggle. That acknowledge enters through an internal STAGES-deep flop synchronizer. The block sits in the sending clock domain, and the receiving side pairs it with the existing multi-flop synchronizer on HsTx_REQ.

## Interface
- WIDTH, 8, data word width (≥1)
- STAGES, 2, flop stages in the HsTx_ACK_ASYNC synchronizer (≥2)

- HsTx_CLK  input  1  single clock; all state updates on rising edge
- HsTx_RST  input  1  reset, synchronous and active-high
- HsTx_DATA_IN  input  WIDTH  word to send; sampled only on acceptance
- HsTx_VALID  input  1  word available
- HsTx_READY  output  1  block can accept a word
- HsTx_DATA_OUT  output  WIDTH  registered word presented to the destination domain
- HsTx_REQ  output  1  registered request toggle
- HsTx_ACK_ASYNC  input  1  acknowledge toggle from the destination domain (asynchronous)
- HsTx_DONE  output  1  registered one-cycle pulse when a transfer is acknowledged
- HsTx_ERR  output  1  sticky protocol-error flag

## Operation
- Ack synchronizer: sync[0] <= HsTx_ACK_ASYNC; sync[k] <= sync[k-1]; ack_s = sync[STAGES-1]. Only ack_s is used.
- FSM states: IDLE, SETUP, WAIT_ACK.
- IDLE: HsTx_READY = 1 (decode of state, gated low while HsTx_RST = 1).
  - On HsTx_VALID & HsTx_READY: capture HsTx_DATA_IN into HsTx_DATA_OUT and go to SETUP.
- SETUP: lasts exactly one cycle, so data is registered one edge before the request toggles. HsTx_REQ <= ~HsTx_REQ, then go to WAIT_ACK.
- WAIT_ACK: when ack_s == HsTx_REQ, go to IDLE and set HsTx_DONE = 1 for exactly one cycle. Otherwise remain in WAIT_ACK with no timeout.
- HsTx_DATA_OUT changes only on acceptance. It is stable through SETUP and WAIT_ACK, and holds its last value in IDLE.
- HsTx_VALID while HsTx_READY = 0 is ignored: no capture and no queuing.
- Error detection: in IDLE or SETUP, if ack_s != HsTx_REQ, set HsTx_ERR = 1. It stays set until reset; FSM operation is unaffected.
- Reset (any state, including mid-transfer), applied at the next rising edge:
  - state = IDLE
  - HsTx_REQ = 0, HsTx_DATA_OUT = 0, HsTx_DONE = 0, HsTx_ERR = 0
  - all sync flops = 0
  - The destination must be reset together with this block.
- HsTx_REQ toggles at most once per transfer and is driven directly from a flop (glitch-free).

## Timing
- Acceptance: the edge T where HsTx_VALID & HsTx_READY is sampled high.
- After edge T: HsTx_DATA_OUT is valid, HsTx_READY = 0.
- After edge T+1: HsTx_REQ toggled.
- Loopback (HsTx_ACK_ASYNC tied to HsTx_REQ):
  - ack_s matches after edge T+1+STAGES.
  - After edge T+2+STAGES: state IDLE, HsTx_DONE = 1 for one cycle, HsTx_READY = 1.
- Earliest next acceptance: edge T+3+STAGES, so HsTx_VALID held high gives one word per STAGES+3 cycles.
- HsTx_DONE and HsTx_READY are both high in the first IDLE cycle. A word may be accepted at the end of that cycle.
- External ack toggle sampled by sync[0] at edge A: completion (IDLE, DONE) follows after edge A+STAGES.
- Reset outputs while HsTx_RST = 1 (after the first edge): READY = 0, REQ = 0, DATA_OUT = 0, DONE = 0, ERR = 0. READY = 1 in the first cycle after HsTx_RST falls.

## Test plan
- Reset: assert HsTx_RST for 3 cycles with HsTx_ACK_ASYNC = 0 -> all outputs 0 during reset; HsTx_READY = 1 in the first cycle after release.
- Single loopback transfer, STAGES = 2: DATA_IN = 0xA5, VALID pulsed at edge T:
  - DATA_OUT = 0xA5 after edge T
  - REQ = 1 after edge T+1
  - DONE high exactly one cycle, after edge T+4
  - ERR = 0
- Back-to-back loopback: VALID held high, words 0x01, 0x02, 0x03 -> accepted at edges T, T+5, T+10; REQ toggles 1, 0, 1; three DONE pulses; DATA_OUT never changes outside acceptance edges.
- Delayed ack: return the ack toggle 20 cycles after REQ, and change DATA_IN every cycle meanwhile -> READY = 0 and DATA_OUT stable for the whole wait; DONE 2 cycles after the ack edge is sampled (STAGES = 2).
- Spurious ack: toggle HsTx_ACK_ASYNC while IDLE -> ERR = 1 STAGES+1 cycles later and stays 1 until HsTx_RST.
- Reset mid-transfer: assert HsTx_RST in WAIT_ACK -> REQ = 0, DATA_OUT = 0, state IDLE; a subsequent loopback transfer of 0x3C completes normally with ERR = 0.

Source files
------------

// File: rtl/cdc_hs_tx_if.sv
// cdc_hs_tx_if
// Bundles the word/handshake signals of the toggle-handshake CDC transmitter.
//   HsTx_DATA_IN   : word offered by the source logic
//   HsTx_VALID     : source has a word
//   HsTx_READY     : transmitter can accept a word
//   HsTx_DATA_OUT  : word held stable towards the destination domain
//   HsTx_REQ       : request toggle towards the destination domain
//   HsTx_ACK_ASYNC : acknowledge toggle returned by the destination (async)
//   HsTx_DONE      : one-cycle pulse when a transfer has been acknowledged
//   HsTx_ERR       : sticky protocol-error flag
// Modport "slave" is the transmitter itself; "master" is its environment.
interface cdc_hs_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] HsTx_DATA_IN;
  logic             HsTx_VALID;
  logic             HsTx_READY;
  logic [WIDTH-1:0] HsTx_DATA_OUT;
  logic             HsTx_REQ;
  logic             HsTx_ACK_ASYNC;
  logic             HsTx_DONE;
  logic             HsTx_ERR;

  modport slave (
    input  HsTx_DATA_IN,
    input  HsTx_VALID,
    input  HsTx_ACK_ASYNC,
    output HsTx_READY,
    output HsTx_DATA_OUT,
    output HsTx_REQ,
    output HsTx_DONE,
    output HsTx_ERR
  );

  modport master (
    output HsTx_DATA_IN,
    output HsTx_VALID,
    output HsTx_ACK_ASYNC,
    input  HsTx_READY,
    input  HsTx_DATA_OUT,
    input  HsTx_REQ,
    input  HsTx_DONE,
    input  HsTx_ERR
  );
endinterface

// File: rtl/cdc_hs_tx.sv
// cdc_hs_tx
// Transmitting end of the toggle-handshake clock-domain-crossing link.
// A word accepted over valid/ready is registered onto HsTx_DATA_OUT, the
// request line is toggled one cycle later, and the block waits until the
// synchronized acknowledge toggle matches the request again.
// Ports:
//   HsTx_CLK : sending-domain clock, rising edge
//   HsTx_RST : synchronous active-high reset
//   bus      : cdc_hs_tx_if.slave (data, valid/ready, req/ack, done, err)
// Parameters:
//   WIDTH  : data word width (>= 1)
//   STAGES : flop stages on the acknowledge synchronizer (>= 2)
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | ready for a new word; request and acknowledge should match
// S_SETUP    | data registered, request toggles on the next edge
// S_WAIT_ACK | request outstanding, waiting for the acknowledge to match
module cdc_hs_tx #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic      HsTx_CLK,
  input  logic      HsTx_RST,
  cdc_hs_tx_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SETUP    = 2'd1,
    S_WAIT_ACK = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [STAGES-1:0] ack_sync_q;
  logic              ack_s;

  logic [WIDTH-1:0]  data_q;
  logic              req_q;
  logic              done_q;
  logic              err_q;

  logic              ready;
  logic              capture;
  logic              toggle_req;
  logic              done_d;
  logic              err_set;

  // Acknowledge synchronizer; only the last stage is ever observed.
  always_ff @(posedge HsTx_CLK) begin
    if (HsTx_RST) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[STAGES-2:0], bus.HsTx_ACK_ASYNC};
    end
  end

  assign ack_s = ack_sync_q[STAGES-1];

  // READY is a state decode, held low during reset so nothing is accepted
  // on an edge that is also clearing the block.
  assign ready = (state_q == S_IDLE) && !HsTx_RST;

  always_ff @(posedge HsTx_CLK) begin
    if (HsTx_RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    toggle_req = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.HsTx_VALID && ready) begin
          capture = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        // Data was registered on the previous edge, so the destination
        // never sees the request toggle before the word is stable.
        toggle_req = 1'b1;
        state_d    = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (ack_s == req_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outside WAIT_ACK the acknowledge has no reason to differ from the
  // request; a mismatch there means the far side toggled on its own.
  assign err_set = (state_q != S_WAIT_ACK) && (ack_s != req_q);

  always_ff @(posedge HsTx_CLK) begin
    if (HsTx_RST) begin
      data_q <= '0;
      req_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (capture) begin
        data_q <= bus.HsTx_DATA_IN;
      end
      if (toggle_req) begin
        req_q <= ~req_q;
      end
      done_q <= done_d;
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.HsTx_READY    = ready;
  assign bus.HsTx_DATA_OUT = data_q;
  assign bus.HsTx_REQ      = req_q;
  assign bus.HsTx_DONE     = done_q;
  assign bus.HsTx_ERR      = err_q;

endmodule

// File: tb/tb_cdc_hs_tx.sv
module tb_cdc_hs_tx;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             req;
  } exp_t;

  logic clk;
  logic rst;
  logic loop_en;
  logic ack_man;
  int   n_tests;
  int   n_fail;
  int   cyc;
  logic model_req;
  exp_t exp_q[$];

  logic             pre_acc;
  logic             pre_rst;
  logic [WIDTH-1:0] prev_data;

  cdc_hs_tx_if #(.WIDTH(WIDTH)) bus ();

  cdc_hs_tx #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .HsTx_CLK (clk),
    .HsTx_RST (rst),
    .bus      (bus.slave)
  );

  assign bus.HsTx_ACK_ASYNC = loop_en ? bus.HsTx_REQ : ack_man;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  // Handshake/reset state as seen just before each edge.
  always @(posedge clk) begin
    pre_acc = bus.HsTx_VALID && bus.HsTx_READY;
    pre_rst = rst;
  end

  // Monitor: pops the scoreboard on every DONE pulse and watches DATA_OUT.
  always @(negedge clk) begin
    cyc++;
    if (!rst && bus.HsTx_DONE === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL done_unexpected: DONE=1 with empty scoreboard (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_data", bus.HsTx_DATA_OUT, e.data);
        chk("done_req", bus.HsTx_REQ, e.req);
      end
    end
    if (bus.HsTx_DATA_OUT !== prev_data) begin
      n_tests++;
      if (!(pre_acc || pre_rst)) begin
        n_fail++;
        $display("FAIL data_stable: DATA_OUT %0h -> %0h without acceptance (cycle %0d)",
                 prev_data, bus.HsTx_DATA_OUT, cyc);
      end
    end
    prev_data = bus.HsTx_DATA_OUT;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    model_req = ~model_req;
    exp_q.push_back('{data: w, req: model_req});
  endtask

  task automatic wait_ready(input int max);
    int k = 0;
    while (bus.HsTx_READY !== 1'b1 && k < max) begin
      step();
      k++;
    end
    chk("ready_timeout", bus.HsTx_READY, 1'b1);
  endtask

  task automatic wait_empty(input int max);
    int k = 0;
    while (exp_q.size() != 0 && k < max) begin
      step();
      k++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    int   rcyc [3];
    logic stable;
    logic [7:0] words [3];

    n_tests   = 0;
    n_fail    = 0;
    cyc       = 0;
    model_req = 1'b0;
    prev_data = '0;
    pre_acc   = 1'b0;
    pre_rst   = 1'b1;
    rst       = 1'b1;
    loop_en   = 1'b0;
    ack_man   = 1'b0;
    bus.HsTx_VALID   = 1'b0;
    bus.HsTx_DATA_IN = '0;

    // Reset: every output low for three cycles, READY as soon as released.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_outputs",
          {bus.HsTx_READY, bus.HsTx_REQ, bus.HsTx_DATA_OUT, bus.HsTx_DONE, bus.HsTx_ERR}, '0);
    end
    rst = 1'b0;
    #1;
    chk("ready_after_reset", bus.HsTx_READY, 1'b1);

    // Single loopback transfer of 0xA5.
    loop_en = 1'b1;
    bus.HsTx_DATA_IN = 8'hA5;
    bus.HsTx_VALID   = 1'b1;
    push_word(8'hA5);
    step();                                    // after T
    bus.HsTx_VALID = 1'b0;
    chk("single_data_T", bus.HsTx_DATA_OUT, 8'hA5);
    chk("single_ready_T", bus.HsTx_READY, 1'b0);
    chk("single_req_T", bus.HsTx_REQ, 1'b0);
    step();                                    // after T+1
    chk("single_req_T1", bus.HsTx_REQ, 1'b1);
    step();                                    // after T+2
    chk("single_done_T2", bus.HsTx_DONE, 1'b0);
    step();                                    // after T+3
    chk("single_done_T3", bus.HsTx_DONE, 1'b0);
    step();                                    // after T+4
    chk("single_done_T4", bus.HsTx_DONE, 1'b1);
    chk("single_ready_T4", bus.HsTx_READY, 1'b1);
    step();                                    // after T+5
    chk("single_done_T5", bus.HsTx_DONE, 1'b0);
    chk("single_err", bus.HsTx_ERR, 1'b0);

    // Back-to-back loopback with VALID held: one word per STAGES+3 cycles.
    words[0] = 8'h01;
    words[1] = 8'h02;
    words[2] = 8'h03;
    for (int i = 0; i < 3; i++) begin
      wait_ready(20);
      rcyc[i] = cyc;
      bus.HsTx_DATA_IN = words[i];
      bus.HsTx_VALID   = 1'b1;
      push_word(words[i]);
      step();
      chk("b2b_data", bus.HsTx_DATA_OUT, words[i]);
    end
    bus.HsTx_VALID = 1'b0;
    chk("b2b_spacing1", rcyc[1] - rcyc[0], STAGES + 3);
    chk("b2b_spacing2", rcyc[2] - rcyc[1], STAGES + 3);
    wait_empty(20);
    step();
    chk("b2b_err", bus.HsTx_ERR, 1'b0);

    // Delayed acknowledge driven by hand, DATA_IN churning meanwhile.
    ack_man = model_req;
    loop_en = 1'b0;
    bus.HsTx_DATA_IN = 8'h5A;
    bus.HsTx_VALID   = 1'b1;
    push_word(8'h5A);
    step();                                    // after T
    bus.HsTx_VALID = 1'b0;
    step();                                    // after T+1
    chk("delay_req", bus.HsTx_REQ, model_req);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.HsTx_DATA_IN = 8'($urandom);
      bus.HsTx_VALID   = 1'($urandom);
      step();
      if (bus.HsTx_READY !== 1'b0 || bus.HsTx_DATA_OUT !== 8'h5A || bus.HsTx_DONE !== 1'b0)
        stable = 1'b0;
    end
    bus.HsTx_VALID = 1'b0;
    chk("delay_hold", stable, 1'b1);
    ack_man = model_req;
    step();                                    // after A
    chk("delay_done_A", bus.HsTx_DONE, 1'b0);
    step();                                    // after A+1
    chk("delay_done_A1", bus.HsTx_DONE, 1'b0);
    step();                                    // after A+2
    chk("delay_done_A2", bus.HsTx_DONE, 1'b1);
    chk("delay_err", bus.HsTx_ERR, 1'b0);
    step();

    // Spurious acknowledge while idle.
    ack_man = ~ack_man;
    step();                                    // sync[0]
    chk("spur_err_1", bus.HsTx_ERR, 1'b0);
    step();                                    // sync[1]
    chk("spur_err_2", bus.HsTx_ERR, 1'b0);
    step();
    chk("spur_err_3", bus.HsTx_ERR, 1'b1);
    ack_man = ~ack_man;
    repeat (5) step();
    chk("spur_err_sticky", bus.HsTx_ERR, 1'b1);

    // Reset in the middle of a transfer that never gets acknowledged.
    bus.HsTx_DATA_IN = 8'h77;
    bus.HsTx_VALID   = 1'b1;
    model_req = ~model_req;
    step();
    bus.HsTx_VALID = 1'b0;
    repeat (4) step();
    chk("mid_req_pending", bus.HsTx_REQ, model_req);
    chk("mid_ready_low", bus.HsTx_READY, 1'b0);
    rst = 1'b1;
    step();
    chk("mid_reset_outputs",
        {bus.HsTx_READY, bus.HsTx_REQ, bus.HsTx_DATA_OUT, bus.HsTx_DONE, bus.HsTx_ERR}, '0);
    ack_man   = 1'b0;
    model_req = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_ready_release", bus.HsTx_READY, 1'b1);
    loop_en = 1'b1;
    bus.HsTx_DATA_IN = 8'h3C;
    bus.HsTx_VALID   = 1'b1;
    push_word(8'h3C);
    step();
    bus.HsTx_VALID = 1'b0;
    chk("post_data", bus.HsTx_DATA_OUT, 8'h3C);
    wait_empty(20);
    step();
    chk("post_err", bus.HsTx_ERR, 1'b0);
    chk("post_ready", bus.HsTx_READY, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
